// File: rtl/flit_deserializer_credit_if.sv
// -----------------------------------------------------------------------------
// flit_deserializer_credit_if
// Bundles the two buses of the flit deserializer:
//   - flit link from the router ejection port (data_in, dest_in, is_tail_in,
//     send_in) and its credit return (credit_out)
//   - AXI-Stream master beat output (axis_tvalid/tready/tdata/tlast/tdest)
//   - sticky protocol-violation status (overflow_err)
// Modports:
//   master : the environment (router side feeding flits, stream sink)
//   slave  : the deserializer itself
// -----------------------------------------------------------------------------
interface flit_deserializer_credit_if #(
    parameter int FLIT_WIDTH  = 128,
    parameter int TDATA_WIDTH = 512,
    parameter int TDEST_WIDTH = 6
);
    logic [FLIT_WIDTH-1:0]  data_in;
    logic [TDEST_WIDTH-1:0] dest_in;
    logic                   is_tail_in;
    logic                   send_in;
    logic                   credit_out;
    logic                   axis_tvalid;
    logic                   axis_tready;
    logic [TDATA_WIDTH-1:0] axis_tdata;
    logic                   axis_tlast;
    logic [TDEST_WIDTH-1:0] axis_tdest;
    logic                   overflow_err;

    modport master (
        output data_in, dest_in, is_tail_in, send_in, axis_tready,
        input  credit_out, axis_tvalid, axis_tdata, axis_tlast, axis_tdest, overflow_err
    );

    modport slave (
        input  data_in, dest_in, is_tail_in, send_in, axis_tready,
        output credit_out, axis_tvalid, axis_tdata, axis_tlast, axis_tdest, overflow_err
    );
endinterface

// File: rtl/flit_deserializer_credit.sv
// -----------------------------------------------------------------------------
// flit_deserializer_credit
// Receive end of the ring flit link. Flits arrive with send/credit flow control,
// are buffered in a small FIFO, and SERIALIZATION_FACTOR flits (or fewer, when
// a tail flit ends the packet early) are reassembled into one AXI-Stream beat.
// Ports:
//   clk   : single clock
//   rst_n : asynchronous active-low reset
//   bus   : flit link in, credit out, AXIS master out, overflow_err status
// -----------------------------------------------------------------------------
module flit_deserializer_credit #(
    parameter int TDEST_WIDTH          = 6,
    parameter int TDATA_WIDTH          = 512,
    parameter int SERIALIZATION_FACTOR = 4,
    parameter int FLIT_BUFFER_DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    flit_deserializer_credit_if.slave     bus
);
    localparam int FLIT_WIDTH = TDATA_WIDTH / SERIALIZATION_FACTOR;
    localparam int ENTRY_W    = FLIT_WIDTH + TDEST_WIDTH + 1;
    localparam int PTR_W      = (FLIT_BUFFER_DEPTH > 1) ? $clog2(FLIT_BUFFER_DEPTH) : 1;
    localparam int CNT_W      = $clog2(FLIT_BUFFER_DEPTH + 1);
    localparam int IDX_W      = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;

    // FIFO entry layout: {data, dest, tail}
    logic [ENTRY_W-1:0]     mem_q [FLIT_BUFFER_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [TDATA_WIDTH-1:0] partial_q, partial_d;
    logic [TDEST_WIDTH-1:0] partial_dest_q, partial_dest_d;
    logic                   credit_q, credit_d;
    logic                   tvalid_q, tvalid_d;
    logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                   tlast_q, tlast_d;
    logic [TDEST_WIDTH-1:0] tdest_q, tdest_d;
    logic                   overflow_q, overflow_d;

    logic [ENTRY_W-1:0]     head_s;
    logic [FLIT_WIDTH-1:0]  head_data_s;
    logic [TDEST_WIDTH-1:0] head_dest_s;
    logic                   head_tail_s;
    logic                   full_s, empty_s, head_last_s, out_free_s, push_s, pop_s;
    logic [TDATA_WIDTH-1:0] beat_s;
    logic [TDEST_WIDTH-1:0] beat_dest_s;

    // Next-state logic: FIFO control, pop decision, beat assembly and output load
    always_comb begin
        head_s      = mem_q[rd_ptr_q];
        head_data_s = head_s[ENTRY_W-1 -: FLIT_WIDTH];
        head_dest_s = head_s[TDEST_WIDTH:1];
        head_tail_s = head_s[0];
        full_s      = (count_q == CNT_W'(FLIT_BUFFER_DEPTH));
        empty_s     = (count_q == {CNT_W{1'b0}});
        // The head finishes a beat when it fills the last slice or ends the packet
        head_last_s = (idx_q == IDX_W'(SERIALIZATION_FACTOR - 1)) || head_tail_s;
        out_free_s  = !tvalid_q || bus.axis_tready;
        push_s      = bus.send_in && !full_s;
        // Non-completing flits always drain; a completing flit waits for the output register
        pop_s       = !empty_s && (!head_last_s || out_free_s);

        // Insert the head flit at slice idx; slices above idx stay zero
        beat_s = partial_q;
        for (int k = 0; k < SERIALIZATION_FACTOR; k++) begin
            if (idx_q == IDX_W'(k)) begin
                beat_s[k*FLIT_WIDTH +: FLIT_WIDTH] = head_data_s;
            end else begin
                beat_s[k*FLIT_WIDTH +: FLIT_WIDTH] = partial_q[k*FLIT_WIDTH +: FLIT_WIDTH];
            end
        end
        // Destination comes from the first flit of the beat only
        beat_dest_s = (idx_q == {IDX_W{1'b0}}) ? head_dest_s : partial_dest_q;

        wr_ptr_d = push_s ? ((wr_ptr_q == PTR_W'(FLIT_BUFFER_DEPTH - 1)) ? {PTR_W{1'b0}}
                                                                       : wr_ptr_q + PTR_W'(1))
                          : wr_ptr_q;
        rd_ptr_d = pop_s  ? ((rd_ptr_q == PTR_W'(FLIT_BUFFER_DEPTH - 1)) ? {PTR_W{1'b0}}
                                                                       : rd_ptr_q + PTR_W'(1))
                          : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (pop_s && head_last_s) begin
            idx_d          = {IDX_W{1'b0}};
            partial_d      = {TDATA_WIDTH{1'b0}};
            partial_dest_d = partial_dest_q;
            tvalid_d       = 1'b1;
            tdata_d        = beat_s;
            tlast_d        = head_tail_s;
            tdest_d        = beat_dest_s;
        end else if (pop_s) begin
            idx_d          = idx_q + IDX_W'(1);
            partial_d      = beat_s;
            partial_dest_d = beat_dest_s;
            tvalid_d       = tvalid_q && !bus.axis_tready;
            tdata_d        = tdata_q;
            tlast_d        = tlast_q;
            tdest_d        = tdest_q;
        end else begin
            idx_d          = idx_q;
            partial_d      = partial_q;
            partial_dest_d = partial_dest_q;
            tvalid_d       = tvalid_q && !bus.axis_tready;
            tdata_d        = tdata_q;
            tlast_d        = tlast_q;
            tdest_d        = tdest_q;
        end

        credit_d   = pop_s;
        overflow_d = overflow_q || (bus.send_in && full_s);
    end

    // Control, assembly and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q       <= {PTR_W{1'b0}};
            rd_ptr_q       <= {PTR_W{1'b0}};
            count_q        <= {CNT_W{1'b0}};
            idx_q          <= {IDX_W{1'b0}};
            partial_q      <= {TDATA_WIDTH{1'b0}};
            partial_dest_q <= {TDEST_WIDTH{1'b0}};
            credit_q       <= 1'b0;
            tvalid_q       <= 1'b0;
            tdata_q        <= {TDATA_WIDTH{1'b0}};
            tlast_q        <= 1'b0;
            tdest_q        <= {TDEST_WIDTH{1'b0}};
            overflow_q     <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            idx_q          <= idx_d;
            partial_q      <= partial_d;
            partial_dest_q <= partial_dest_d;
            credit_q       <= credit_d;
            tvalid_q       <= tvalid_d;
            tdata_q        <= tdata_d;
            tlast_q        <= tlast_d;
            tdest_q        <= tdest_d;
            overflow_q     <= overflow_d;
        end
    end

    // FIFO storage write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FLIT_BUFFER_DEPTH; i++) begin
                mem_q[i] <= {ENTRY_W{1'b0}};
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= {bus.data_in, bus.dest_in, bus.is_tail_in};
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    assign bus.credit_out   = credit_q;
    assign bus.axis_tvalid  = tvalid_q;
    assign bus.axis_tdata   = tdata_q;
    assign bus.axis_tlast   = tlast_q;
    assign bus.axis_tdest   = tdest_q;
    assign bus.overflow_err = overflow_q;
endmodule

// File: tb/tb_flit_deserializer_credit.sv
// -----------------------------------------------------------------------------
// tb_flit_deserializer_credit
// Directed bench for flit_deserializer_credit with default parameters
// (512-bit beats, 4 flits of 128 bits, 4-entry flit buffer).
// -----------------------------------------------------------------------------
module tb_flit_deserializer_credit;
    localparam int FW    = 128;
    localparam int DW    = 512;
    localparam int DESTW = 6;
    localparam int SF    = 4;
    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;

    flit_deserializer_credit_if #(.FLIT_WIDTH(FW), .TDATA_WIDTH(DW), .TDEST_WIDTH(DESTW)) bus ();

    flit_deserializer_credit #(
        .TDEST_WIDTH(DESTW), .TDATA_WIDTH(DW),
        .SERIALIZATION_FACTOR(SF), .FLIT_BUFFER_DEPTH(DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks_cnt = 0;
    int errors_cnt = 0;
    int cyc = 0;
    int credits_seen = 0;
    int flits_sent = 0;
    int last_send_cyc = 0;

    logic [DW-1:0]    got_data[$];
    logic [DESTW-1:0] got_dest[$];
    logic             got_last[$];
    int               got_cyc[$];
    logic [DW-1:0]    exp_data[$];
    logic [DESTW-1:0] exp_dest[$];
    logic             exp_last[$];

    // Reference assembly state
    logic [DW-1:0]    m_data = '0;
    logic [DESTW-1:0] m_dest = '0;
    int               m_idx  = 0;

    task automatic check_value(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, then advance past the rising edge
    task automatic step();
        @(negedge clk);
        if (bus.credit_out === 1'b1) credits_seen++;
        if (bus.axis_tvalid === 1'b1 && bus.axis_tready === 1'b1) begin
            got_data.push_back(bus.axis_tdata);
            got_dest.push_back(bus.axis_tdest);
            got_last.push_back(bus.axis_tlast);
            got_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic model_push(input logic [FW-1:0] d, input logic [DESTW-1:0] dst, input logic tl);
        if (m_idx == 0) m_dest = dst;
        m_data[m_idx*FW +: FW] = d;
        if (m_idx == SF - 1 || tl) begin
            exp_data.push_back(m_data);
            exp_dest.push_back(m_dest);
            exp_last.push_back(tl);
            m_data = '0;
            m_idx  = 0;
        end else begin
            m_idx++;
        end
    endtask

    // Send one flit, waiting for a credit (bounded)
    task automatic send_flit(input logic [FW-1:0] d, input logic [DESTW-1:0] dst, input logic tl);
        int waited = 0;
        while ((flits_sent - credits_seen) >= DEPTH && waited < 64) begin
            step();
            waited++;
        end
        if (waited >= 64) check_value("credit_wait_timeout", 512'(waited), 512'(0));
        bus.send_in    = 1'b1;
        bus.data_in    = d;
        bus.dest_in    = dst;
        bus.is_tail_in = tl;
        last_send_cyc  = cyc;
        step();
        bus.send_in    = 1'b0;
        flits_sent++;
        model_push(d, dst, tl);
    endtask

    task automatic compare_beats(input string tag);
        check_value({tag, "_beat_count"}, 512'(got_data.size()), 512'(exp_data.size()));
        while (got_data.size() > 0 && exp_data.size() > 0) begin
            check_value({tag, "_tdata"}, got_data.pop_front(), exp_data.pop_front());
            check_value({tag, "_tdest"}, 512'(got_dest.pop_front()), 512'(exp_dest.pop_front()));
            check_value({tag, "_tlast"}, 512'(got_last.pop_front()), 512'(exp_last.pop_front()));
        end
        got_data.delete(); got_dest.delete(); got_last.delete(); got_cyc.delete();
        exp_data.delete(); exp_dest.delete(); exp_last.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check_value({tag, "_tvalid"}, 512'(bus.axis_tvalid), 512'(0));
        check_value({tag, "_tdata"},  bus.axis_tdata, 512'(0));
        check_value({tag, "_tlast"},  512'(bus.axis_tlast), 512'(0));
        check_value({tag, "_tdest"},  512'(bus.axis_tdest), 512'(0));
        check_value({tag, "_credit"}, 512'(bus.credit_out), 512'(0));
        check_value({tag, "_ovf"},    512'(bus.overflow_err), 512'(0));
    endtask

    // Global time limit
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int bubbles;
        bus.send_in = 1'b0; bus.data_in = '0; bus.dest_in = '0;
        bus.is_tail_in = 1'b0; bus.axis_tready = 1'b0;
        rst_n = 1'b0;
        idle(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        idle(2);

        // Test 1: full 4-flit packet, sink ready
        bus.axis_tready = 1'b1;
        c0 = credits_seen;
        for (int i = 1; i <= 4; i++) send_flit(FW'(i), 6'h2A, (i == 4));
        idle(6);
        check_value("t1_beat_seen", 512'(got_data.size()), 512'(1));
        if (got_data.size() > 0) begin
            check_value("t1_slice0", 512'(got_data[0][127:0]), 512'(1));
            check_value("t1_slice3", 512'(got_data[0][511:384]), 512'(4));
            check_value("t1_latency", 512'(got_cyc[0]), 512'(last_send_cyc + 2));
        end
        check_value("t1_credits", 512'(credits_seen - c0), 512'(4));
        check_value("t1_beat_value", exp_data.size() > 0 ? exp_data[0] : 512'(0),
                    {128'h4, 128'h3, 128'h2, 128'h1});
        compare_beats("t1");

        // Test 2: 3-flit packet then a 4-flit packet
        for (int i = 0; i < 3; i++) send_flit(FW'(8'h11 + i), 6'h05, (i == 2));
        for (int i = 0; i < 4; i++) send_flit(FW'(8'h21 + i), 6'h06, (i == 3));
        idle(6);
        check_value("t2_beats", 512'(got_data.size()), 512'(2));
        if (got_data.size() > 1) begin
            check_value("t2_short_beat", got_data[0], {128'h0, 128'h13, 128'h12, 128'h11});
            check_value("t2_short_tlast", 512'(got_last[0]), 512'(1));
            check_value("t2_next_beat", got_data[1], {128'h24, 128'h23, 128'h22, 128'h21});
        end
        compare_beats("t2");

        // Test 3: stalled sink while 8 flits are sent on credits
        bus.axis_tready = 1'b0;
        c0 = credits_seen;
        for (int i = 0; i < 8; i++) send_flit(FW'(8'h31 + i), (i < 4) ? 6'h07 : 6'h08, (i == 3 || i == 7));
        for (int i = 0; i < 10; i++) begin
            step();
            check_value("t3_hold_tvalid", 512'(bus.axis_tvalid), 512'(1));
            check_value("t3_hold_tdata", bus.axis_tdata, {128'h34, 128'h33, 128'h32, 128'h31});
        end
        // Four pops for the first beat plus three assembled flits; the completing flit waits
        check_value("t3_credits_stalled", 512'(credits_seen - c0), 512'(7));
        check_value("t3_no_beats_stalled", 512'(got_data.size()), 512'(0));
        bus.axis_tready = 1'b1;
        idle(6);
        check_value("t3_credits_total", 512'(credits_seen - c0), 512'(8));
        compare_beats("t3");

        // Test 4: 40 flits streamed, two-beat packets
        for (int i = 0; i < 40; i++) send_flit(FW'(16'h100 + i), DESTW'(i), (i % 8 == 7));
        idle(8);
        bubbles = 0;
        for (int i = 1; i < got_cyc.size(); i++) begin
            if (got_cyc[i] - got_cyc[i-1] != 4) bubbles++;
        end
        check_value("t4_bubbles", 512'(bubbles), 512'(0));
        check_value("t4_span", 512'(got_cyc.size() == 10 ? got_cyc[9] - got_cyc[0] : -1), 512'(36));
        check_value("t4_ovf", 512'(bus.overflow_err), 512'(0));
        compare_beats("t4");

        // Test 5: overflow with a pending beat and a blocked head
        bus.axis_tready = 1'b0;
        for (int i = 0; i < 4; i++) send_flit(FW'(8'h41 + i), 6'h09, (i == 3));
        send_flit(FW'(8'h51), 6'h0C, 1'b1);
        idle(3);
        for (int i = 0; i < 6; i++) begin
            bus.send_in = 1'b1; bus.data_in = FW'(8'hE0 + i);
            bus.dest_in = 6'h0D; bus.is_tail_in = 1'b1;
            step();
            // Buffer holds the blocked head plus three more flits
            if (i < 3) begin
                flits_sent++;
                model_push(FW'(8'hE0 + i), 6'h0D, 1'b1);
            end
        end
        bus.send_in = 1'b0;
        check_value("t5_ovf_set", 512'(bus.overflow_err), 512'(1));
        bus.axis_tready = 1'b1;
        idle(10);
        check_value("t5_ovf_sticky", 512'(bus.overflow_err), 512'(1));
        compare_beats("t5");

        // Test 6: reset mid-beat, then a fresh packet
        send_flit(FW'(8'h61), 6'h0A, 1'b0);
        send_flit(FW'(8'h62), 6'h0A, 1'b0);
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_async_reset");
        for (int i = 0; i < 3; i++) begin
            step();
            check_all_zero("t6_in_reset");
        end
        rst_n = 1'b1;
        got_data.delete(); got_dest.delete(); got_last.delete(); got_cyc.delete();
        exp_data.delete(); exp_dest.delete(); exp_last.delete();
        m_data = '0; m_idx = 0;
        credits_seen = 0; flits_sent = 0;
        idle(2);
        for (int i = 0; i < 4; i++) send_flit(FW'(8'h71 + i), 6'h0B, (i == 3));
        idle(6);
        check_value("t6_credits", 512'(credits_seen), 512'(4));
        check_value("t6_beats", 512'(got_data.size()), 512'(1));
        if (got_data.size() > 0) begin
            check_value("t6_beat", got_data[0], {128'h74, 128'h73, 128'h72, 128'h71});
            check_value("t6_dest", 512'(got_dest[0]), 512'(6'h0B));
        end
        compare_beats("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
